decode_issue: RTL and testbench

Parametrised decode-and-issue stage for the superscalar RV32I core. It sits between fetch and the register-read/execute stages and latches one fetch bundle of LANES instructions. Each lane is decoded with the existing `decoder` module. The stage issues in order the longest prefix of pending lanes that has no intra-bundle RAW dependency, so dependent bundles are split across cycles. It also resolves fetch-predicted-taken lanes that are not control-flow instructions, by redirecting fetch to the fall-through PC and dropping younger lanes.

---
 rtl/decode_issue.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_decode_issue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// Decode-and-issue stage: latches one fetch bundle, decodes every lane and issues the
// longest RAW-free prefix of pending lanes each cycle, correcting bogus taken predictions.

// RV32I lane decoder producing one control word per instruction.
module decoder #(
  parameter int unsigned CTRL_W = 16
) (
  input  logic [31:0]       inst,
  output logic [CTRL_W-1:0] ctrl
);
  localparam int unsigned BASE_W = 16;

  localparam int unsigned C_BRANCH  = 0;
  localparam int unsigned C_JAL     = 1;
  localparam int unsigned C_JALR    = 2;
  localparam int unsigned C_LOAD    = 3;
  localparam int unsigned C_STORE   = 4;
  localparam int unsigned C_ALU_IMM = 5;
  localparam int unsigned C_ALU_REG = 6;
  localparam int unsigned C_LUI     = 7;
  localparam int unsigned C_AUIPC   = 8;
  localparam int unsigned C_WRITE   = 9;
  localparam int unsigned C_RS1     = 10;
  localparam int unsigned C_RS2     = 11;
  localparam int unsigned C_FENCE   = 12;
  localparam int unsigned C_SYSTEM  = 13;
  localparam int unsigned C_ILLEGAL = 14;
  localparam int unsigned C_ALT     = 15;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0f;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [6:0]        funct7;
  logic [11:0]       imm12;
  logic [BASE_W-1:0] c;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign funct7 = inst[31:25];
  assign imm12  = inst[31:20];

  always_comb begin
    c = '0;
    case (opcode)
      OP_LUI: begin
        c[C_LUI]   = 1'b1;
        c[C_WRITE] = 1'b1;
      end
      OP_AUIPC: begin
        c[C_AUIPC] = 1'b1;
        c[C_WRITE] = 1'b1;
      end
      OP_JAL: begin
        c[C_JAL]   = 1'b1;
        c[C_WRITE] = 1'b1;
      end
      OP_JALR: begin
        c[C_JALR]    = 1'b1;
        c[C_WRITE]   = 1'b1;
        c[C_RS1]     = 1'b1;
        c[C_ILLEGAL] = (funct3 != 3'd0);
      end
      OP_BRANCH: begin
        c[C_BRANCH]  = 1'b1;
        c[C_RS1]     = 1'b1;
        c[C_RS2]     = 1'b1;
        c[C_ILLEGAL] = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OP_LOAD: begin
        c[C_LOAD]    = 1'b1;
        c[C_WRITE]   = 1'b1;
        c[C_RS1]     = 1'b1;
        c[C_ILLEGAL] = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OP_STORE: begin
        c[C_STORE]   = 1'b1;
        c[C_RS1]     = 1'b1;
        c[C_RS2]     = 1'b1;
        c[C_ILLEGAL] = (funct3 > 3'd2);
      end
      OP_IMM: begin
        c[C_ALU_IMM] = 1'b1;
        c[C_WRITE]   = 1'b1;
        c[C_RS1]     = 1'b1;
        // Only the shift-immediate forms constrain funct7
        if (funct3 == 3'd1) begin
          c[C_ILLEGAL] = (funct7 != 7'h00);
        end else if (funct3 == 3'd5) begin
          c[C_ILLEGAL] = (funct7 != 7'h00) && (funct7 != 7'h20);
          c[C_ALT]     = funct7[5];
        end
      end
      OP_REG: begin
        c[C_ALU_REG] = 1'b1;
        c[C_WRITE]   = 1'b1;
        c[C_RS1]     = 1'b1;
        c[C_RS2]     = 1'b1;
        c[C_ALT]     = funct7[5];
        c[C_ILLEGAL] = !((funct7 == 7'h00) ||
                         ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      end
      OP_FENCE: begin
        c[C_FENCE]   = 1'b1;
        c[C_ILLEGAL] = (funct3 != 3'd0);
      end
      OP_SYSTEM: begin
        c[C_SYSTEM]  = 1'b1;
        c[C_ILLEGAL] = !((funct3 == 3'd0) && (rs1 == 5'd0) && (rd == 5'd0) &&
                         ((imm12 == 12'd0) || (imm12 == 12'd1)));
      end
      default: c[C_ILLEGAL] = 1'b1;
    endcase
    if ((rd == 5'd0) || c[C_ILLEGAL]) begin
      c[C_WRITE] = 1'b0;
    end
  end

  assign ctrl = CTRL_W'(c);
endmodule

module decode_issue #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned CTRL_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     f_valid_i,
  output logic                     f_ready_o,
  input  logic [32*LANES-1:0]      f_inst_i,
  input  logic [31:0]              f_pc_i,
  input  logic [LANES-1:0]         f_pred_taken_i,
  output logic [LANES-1:0]         d_valid_o,
  input  logic                     d_ready_i,
  output logic [32*LANES-1:0]      d_inst_o,
  output logic [32*LANES-1:0]      d_pc_o,
  output logic [CTRL_W*LANES-1:0]  d_ctrl_o,
  output logic [LANES-1:0]         d_pred_taken_o,
  input  logic                     flush_i,
  output logic                     redirect_o,
  output logic [31:0]              redirect_pc_o
);
  localparam int unsigned IW = 32;

  // Control-flow bit positions of the decoder control word
  localparam int unsigned C_BRANCH = 0;
  localparam int unsigned C_JAL    = 1;
  localparam int unsigned C_JALR   = 2;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;

  logic [IW*LANES-1:0] b_inst;
  logic [31:0]         b_pc;
  logic [LANES-1:0]    b_pred;
  logic [LANES-1:0]    pend;

  logic [CTRL_W-1:0]   ctrl   [LANES];
  logic [6:0]          op_f   [LANES];
  logic [4:0]          rd_f   [LANES];
  logic [4:0]          rs1_f  [LANES];
  logic [4:0]          rs2_f  [LANES];
  logic [LANES-1:0]    writes;
  logic [LANES-1:0]    reads1;
  logic [LANES-1:0]    reads2;

  logic [LANES-1:0]    group;
  logic                started;
  logic                stop;
  logic                dep;
  logic [LANES-1:0]    fix_mask;
  logic                mis_found;
  logic [31:0]         mis_pc;
  logic [LANES-1:0]    load_mask;
  logic                seen_pred;
  logic                take;
  logic                issue;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    decoder #(.CTRL_W(CTRL_W)) u_dec (
      .inst (b_inst[IW*g +: IW]),
      .ctrl (ctrl[g])
    );
    assign d_ctrl_o[CTRL_W*g +: CTRL_W] = ctrl[g];
    assign d_pc_o[IW*g +: IW]           = b_pc + 32'(4 * g);
  end

  // Register usage of each latched lane, taken straight from the opcode
  always_comb begin
    writes = '0;
    reads1 = '0;
    reads2 = '0;
    for (int i = 0; i < LANES; i++) begin
      op_f[i]   = b_inst[IW*i +: 7];
      rd_f[i]   = b_inst[IW*i + 7 +: 5];
      rs1_f[i]  = b_inst[IW*i + 15 +: 5];
      rs2_f[i]  = b_inst[IW*i + 20 +: 5];
      writes[i] = !((op_f[i] == OP_BRANCH) || (op_f[i] == OP_STORE)) && (rd_f[i] != 5'd0);
      reads1[i] = !((op_f[i] == OP_LUI) || (op_f[i] == OP_AUIPC) || (op_f[i] == OP_JAL));
      reads2[i] = (op_f[i] == OP_BRANCH) || (op_f[i] == OP_STORE) || (op_f[i] == OP_REG);
    end
  end

  // Oldest pending lane always goes; younger ones join until the first RAW hazard
  always_comb begin
    group   = '0;
    started = 1'b0;
    stop    = 1'b0;
    dep     = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      if (pend[j] && !stop) begin
        if (!started) begin
          group[j] = 1'b1;
          started  = 1'b1;
        end else begin
          dep = 1'b0;
          for (int i = 0; i < LANES; i++) begin
            if ((i < j) && group[i] && writes[i] &&
                ((reads1[j] && (rd_f[i] == rs1_f[j])) ||
                 (reads2[j] && (rd_f[i] == rs2_f[j])))) begin
              dep = 1'b1;
            end
          end
          if (dep) begin
            stop = 1'b1;
          end else begin
            group[j] = 1'b1;
          end
        end
      end else if (started) begin
        stop = 1'b1;
      end
    end
  end

  // Oldest issued lane predicted taken that is not control flow falls through
  always_comb begin
    mis_found = 1'b0;
    mis_pc    = '0;
    fix_mask  = '0;
    for (int j = 0; j < LANES; j++) begin
      if (!mis_found && group[j] && b_pred[j] &&
          !(ctrl[j][C_BRANCH] || ctrl[j][C_JAL] || ctrl[j][C_JALR])) begin
        mis_found   = 1'b1;
        mis_pc      = b_pc + 32'(4 * j + 4);
        fix_mask[j] = 1'b1;
      end
    end
  end

  // Lanes younger than the oldest predicted-taken lane are dead on arrival
  always_comb begin
    load_mask = '0;
    seen_pred = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!seen_pred) begin
        load_mask[i] = 1'b1;
      end
      if (f_pred_taken_i[i]) begin
        seen_pred = 1'b1;
      end
    end
  end

  assign issue          = d_ready_i && (group != '0);
  assign f_ready_o      = !flush_i && ((pend == '0) || (d_ready_i && (group == pend)));
  assign take           = f_valid_i && f_ready_o;
  assign d_valid_o      = flush_i ? '0 : group;
  assign d_inst_o       = b_inst;
  assign d_pred_taken_o = b_pred & ~fix_mask;
  assign redirect_o     = !flush_i && issue && mis_found;
  assign redirect_pc_o  = mis_pc;

  // Flush beats load, load beats issue (a load only happens when the last group leaves)
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend   <= '0;
      b_inst <= '0;
      b_pc   <= '0;
      b_pred <= '0;
    end else if (flush_i) begin
      pend <= '0;
    end else if (take) begin
      b_inst <= f_inst_i;
      b_pc   <= f_pc_i;
      b_pred <= f_pred_taken_i;
      pend   <= load_mask;
    end else if (issue) begin
      pend <= pend & ~group;
    end
  end
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: 2-lane vector table plus hand-written
// backpressure, flush, reset and 4-lane sequences.
module tb_decode_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  logic         f_valid2 = 1'b0, f_ready2, d_ready2 = 1'b1, redir2;
  logic [63:0]  f_inst2 = '0, d_inst2, d_pc2;
  logic [31:0]  f_pc2 = '0, rpc2, d_ctrl2;
  logic [1:0]   f_pred2 = '0, d_valid2, d_pt2;

  logic         f_valid4 = 1'b0, f_ready4, d_ready4 = 1'b1, redir4;
  logic [127:0] f_inst4 = '0, d_inst4, d_pc4;
  logic [31:0]  f_pc4 = '0, rpc4;
  logic [63:0]  d_ctrl4;
  logic [3:0]   f_pred4 = '0, d_valid4, d_pt4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  decode_issue #(.LANES(2), .CTRL_W(16)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .f_valid_i(f_valid2), .f_ready_o(f_ready2),
    .f_inst_i(f_inst2), .f_pc_i(f_pc2), .f_pred_taken_i(f_pred2), .d_valid_o(d_valid2),
    .d_ready_i(d_ready2), .d_inst_o(d_inst2), .d_pc_o(d_pc2), .d_ctrl_o(d_ctrl2),
    .d_pred_taken_o(d_pt2), .flush_i(flush), .redirect_o(redir2), .redirect_pc_o(rpc2)
  );

  decode_issue #(.LANES(4), .CTRL_W(16)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .f_valid_i(f_valid4), .f_ready_o(f_ready4),
    .f_inst_i(f_inst4), .f_pc_i(f_pc4), .f_pred_taken_i(f_pred4), .d_valid_o(d_valid4),
    .d_ready_i(d_ready4), .d_inst_o(d_inst4), .d_pc_o(d_pc4), .d_ctrl_o(d_ctrl4),
    .d_pred_taken_o(d_pt4), .flush_i(flush), .redirect_o(redir4), .redirect_pc_o(rpc4)
  );

  typedef struct {
    logic [31:0] i0, i1, pc;
    logic [1:0]  pred, m1;
    logic        fr1, rd1;
    logic [31:0] rpc;
    logic [1:0]  pt, m2;
    logic        fr2;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction

  function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
    return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  function automatic vec_t mk(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc,
                              input logic [1:0] pred, input logic [1:0] m1, input logic fr1,
                              input logic rd1, input logic [31:0] rpc, input logic [1:0] pt,
                              input logic [1:0] m2, input logic fr2);
    vec_t v;
    v.i0 = i0; v.i1 = i1; v.pc = pc; v.pred = pred; v.m1 = m1; v.fr1 = fr1;
    v.rd1 = rd1; v.rpc = rpc; v.pt = pt; v.m2 = m2; v.fr2 = fr2;
    return v;
  endfunction

  task automatic load2(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc,
                       input logic [1:0] pred);
    @(negedge clk);
    f_valid2 = 1'b1; f_inst2 = {i1, i0}; f_pc2 = pc; f_pred2 = pred; d_ready2 = 1'b1;
    @(posedge clk);
  endtask

  task automatic load4(input logic [127:0] insts, input logic [31:0] pc, input logic [3:0] pred);
    @(negedge clk);
    f_valid4 = 1'b1; f_inst4 = insts; f_pc4 = pc; f_pred4 = pred; d_ready4 = 1'b1;
    @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    load2(v.i0, v.i1, v.pc, v.pred);
    @(negedge clk); f_valid2 = 1'b0; #1;
    chk($sformatf("v%0d_mask1", idx), 128'(d_valid2), 128'(v.m1));
    chk($sformatf("v%0d_fready1", idx), 128'(f_ready2), 128'(v.fr1));
    chk($sformatf("v%0d_redirect", idx), 128'(redir2), 128'(v.rd1));
    if (v.rd1) chk($sformatf("v%0d_rpc", idx), 128'(rpc2), 128'(v.rpc));
    chk($sformatf("v%0d_predout", idx), 128'(d_pt2), 128'(v.pt));
    chk($sformatf("v%0d_pc", idx), 128'(d_pc2), 128'({v.pc + 32'd4, v.pc}));
    @(posedge clk); @(negedge clk); #1;
    chk($sformatf("v%0d_mask2", idx), 128'(d_valid2), 128'(v.m2));
    chk($sformatf("v%0d_fready2", idx), 128'(f_ready2), 128'(v.fr2));
    @(posedge clk); @(negedge clk); #1;
    chk($sformatf("v%0d_mask3", idx), 128'(d_valid2), 128'(2'b00));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(addi(1,0,1), addi(2,0,2), 32'h100, 2'b00, 2'b11, 1, 0, 0, 2'b00, 2'b00, 1);
    tbl[1] = mk(addi(1,0,1), add(3,1,1), 32'h100, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b10, 1);
    tbl[2] = mk(addi(0,0,1), add(3,1,1), 32'h180, 2'b00, 2'b11, 1, 0, 0, 2'b00, 2'b00, 1);
    tbl[3] = mk(addi(1,0,1), addi(2,0,2), 32'h200, 2'b01, 2'b01, 1, 1, 32'h204, 2'b00, 2'b00, 1);
    tbl[4] = mk(32'h00000463, addi(2,0,2), 32'h200, 2'b01, 2'b01, 1, 0, 0, 2'b01, 2'b00, 1);
    tbl[5] = mk(addi(5,0,3), addi(6,0,4), 32'h300, 2'b10, 2'b11, 1, 1, 32'h308, 2'b00, 2'b00, 1);
    tbl[6] = mk(addi(1,0,1), 32'h00112023, 32'h040, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b10, 1);
    tbl[7] = mk(addi(1,0,1), 32'h000080B7, 32'h050, 2'b00, 2'b11, 1, 0, 0, 2'b00, 2'b00, 1);
    tbl[8] = mk(32'h008000EF, addi(2,0,2), 32'h060, 2'b01, 2'b01, 1, 0, 0, 2'b01, 2'b00, 1);

    #1;
    chk("rst_valid", 128'(d_valid2), 128'(2'b00));
    chk("rst_redirect", 128'(redir2), 128'(1'b0));
    chk("rst_rpc", 128'(rpc2), 128'(32'h0));
    chk("rst_fready", 128'(f_ready2), 128'(1'b1));
    chk("rst_valid4", 128'(d_valid4), 128'(4'b0000));
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // Back-to-back bundles on the 2-lane stage
    load2(addi(1,0,1), addi(2,0,2), 32'h100, 2'b00);
    @(negedge clk); f_inst2 = {addi(4,0,4), addi(3,0,3)}; f_pc2 = 32'h400; #1;
    chk("tput_mask_a", 128'(d_valid2), 128'(2'b11));
    chk("tput_fready_a", 128'(f_ready2), 128'(1'b1));
    @(posedge clk); @(negedge clk); f_valid2 = 1'b0; #1;
    chk("tput_mask_b", 128'(d_valid2), 128'(2'b11));
    chk("tput_pc_b", 128'(d_pc2), 128'({32'h404, 32'h400}));
    @(posedge clk);

    // Backpressure mid-split
    load2(addi(1,0,1), add(3,1,1), 32'h100, 2'b00);
    @(negedge clk); f_valid2 = 1'b0; d_ready2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_mask", c), 128'(d_valid2), 128'(2'b01));
      chk($sformatf("bp%0d_fready", c), 128'(f_ready2), 128'(1'b0));
      chk($sformatf("bp%0d_inst", c), 128'(d_inst2), 128'({add(3,1,1), addi(1,0,1)}));
      chk($sformatf("bp%0d_pc", c), 128'(d_pc2), 128'({32'h104, 32'h100}));
      chk($sformatf("bp%0d_ctrl", c), 128'(d_ctrl2), 128'({16'h0E40, 16'h0620}));
      @(posedge clk); @(negedge clk);
    end
    d_ready2 = 1'b1; #1;
    chk("bp_resume0", 128'(d_valid2), 128'(2'b01));
    @(posedge clk); @(negedge clk); #1;
    chk("bp_resume1", 128'(d_valid2), 128'(2'b10));
    chk("bp_resume1_fr", 128'(f_ready2), 128'(1'b1));
    @(posedge clk); @(negedge clk); #1;
    chk("bp_done", 128'(d_valid2), 128'(2'b00));

    // Redirect is held back while downstream stalls
    load2(addi(1,0,1), addi(2,0,2), 32'h200, 2'b01);
    @(negedge clk); f_valid2 = 1'b0; d_ready2 = 1'b0; #1;
    chk("bp_redir_lo", 128'(redir2), 128'(1'b0));
    chk("bp_redir_mask", 128'(d_valid2), 128'(2'b01));
    @(posedge clk); @(negedge clk); d_ready2 = 1'b1; #1;
    chk("bp_redir_hi", 128'(redir2), 128'(1'b1));
    chk("bp_redir_pc", 128'(rpc2), 128'(32'h204));
    @(posedge clk);

    // Flush while lane1 pending, then accept the next bundle
    load2(addi(1,0,1), add(3,1,1), 32'h100, 2'b00);
    @(negedge clk); f_valid2 = 1'b0; #1;
    chk("fl_mask0", 128'(d_valid2), 128'(2'b01));
    @(posedge clk); @(negedge clk); flush = 1'b1; #1;
    chk("fl_valid", 128'(d_valid2), 128'(2'b00));
    chk("fl_fready", 128'(f_ready2), 128'(1'b0));
    chk("fl_redirect", 128'(redir2), 128'(1'b0));
    @(posedge clk); @(negedge clk); flush = 1'b0;
    f_valid2 = 1'b1; f_inst2 = {addi(2,0,2), addi(1,0,1)}; f_pc2 = 32'h600; f_pred2 = 2'b00; #1;
    chk("fl_after_valid", 128'(d_valid2), 128'(2'b00));
    chk("fl_after_fready", 128'(f_ready2), 128'(1'b1));
    @(posedge clk); @(negedge clk); f_valid2 = 1'b0; #1;
    chk("fl_next_mask", 128'(d_valid2), 128'(2'b11));
    chk("fl_next_pc", 128'(d_pc2), 128'({32'h604, 32'h600}));
    @(posedge clk);

    // Flush and misprediction together: flush wins
    load2(addi(1,0,1), addi(2,0,2), 32'h200, 2'b01);
    @(negedge clk); f_valid2 = 1'b0; flush = 1'b1; #1;
    chk("flr_redirect", 128'(redir2), 128'(1'b0));
    chk("flr_valid", 128'(d_valid2), 128'(2'b00));
    @(posedge clk); @(negedge clk); flush = 1'b0; #1;
    chk("flr_dropped", 128'(d_valid2), 128'(2'b00));

    // Asynchronous reset mid-split
    load2(addi(1,0,1), add(3,1,1), 32'h100, 2'b00);
    @(negedge clk); f_valid2 = 1'b0; #1;
    @(posedge clk); @(negedge clk); #1;
    chk("ar_pending", 128'(d_valid2), 128'(2'b10));
    #1 rst_n = 1'b0; #1;
    chk("ar_valid", 128'(d_valid2), 128'(2'b00));
    chk("ar_fready", 128'(f_ready2), 128'(1'b1));
    @(negedge clk); rst_n = 1'b1;

    // 4-lane dependency chain
    load4({addi(4,2,0), addi(3,0,3), addi(2,1,0), addi(1,0,1)}, 32'h1000, 4'b0000);
    @(negedge clk); f_valid4 = 1'b0; #1;
    chk("ch_g0", 128'(d_valid4), 128'(4'b0001));
    chk("ch_fr0", 128'(f_ready4), 128'(1'b0));
    @(posedge clk); @(negedge clk); #1;
    chk("ch_g1", 128'(d_valid4), 128'(4'b0110));
    chk("ch_fr1", 128'(f_ready4), 128'(1'b0));
    @(posedge clk); @(negedge clk); #1;
    chk("ch_g2", 128'(d_valid4), 128'(4'b1000));
    chk("ch_fr2", 128'(f_ready4), 128'(1'b1));
    @(posedge clk); @(negedge clk); #1;
    chk("ch_done", 128'(d_valid4), 128'(4'b0000));

    // 4-lane full throughput
    load4({addi(4,0,4), addi(3,0,3), addi(2,0,2), addi(1,0,1)}, 32'h1000, 4'b0000);
    @(negedge clk); f_pc4 = 32'h2000; #1;
    chk("t4_mask_a", 128'(d_valid4), 128'(4'b1111));
    chk("t4_fready_a", 128'(f_ready4), 128'(1'b1));
    chk("t4_pc_a", 128'(d_pc4[31:0]), 128'(32'h1000));
    @(posedge clk); @(negedge clk); f_valid4 = 1'b0; #1;
    chk("t4_mask_b", 128'(d_valid4), 128'(4'b1111));
    chk("t4_pc_b3", 128'(d_pc4[127:96]), 128'(32'h200C));
    @(posedge clk); @(negedge clk); #1;
    chk("t4_done", 128'(d_valid4), 128'(4'b0000));

    // 4-lane misprediction on lane 2 truncates lane 3
    load4({addi(4,0,4), addi(3,0,3), addi(2,0,2), addi(1,0,1)}, 32'h3000, 4'b0100);
    @(negedge clk); f_valid4 = 1'b0; #1;
    chk("mp4_mask", 128'(d_valid4), 128'(4'b0111));
    chk("mp4_redirect", 128'(redir4), 128'(1'b1));
    chk("mp4_rpc", 128'(rpc4), 128'(32'h300C));
    chk("mp4_predout", 128'(d_pt4), 128'(4'b0000));
    @(posedge clk); @(negedge clk); #1;
    chk("mp4_done", 128'(d_valid4), 128'(4'b0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
